// File: rtl/ro_pkg.sv
// ro_pkg: shared defaults and helpers for the cochlea readout slot scheduler.
//   N_CH / CNT_W / CH_W  default channel count, slot counter width, channel index width
//   slot_t               {idle, ch} result of the slot-owner decode
//   slot_owner(c)        trailing-zero decode of the slot count into an owning channel
//   bin2gray(b)          binary to reflected Gray code
package ro_pkg;

  localparam int N_CH  = 8;
  localparam int CNT_W = 8;
  localparam int CH_W  = $clog2(N_CH);

  typedef struct packed {
    logic            idle;
    logic [CH_W-1:0] ch;
  } slot_t;

  // The owner is the index of the lowest set bit. Counts with none of the low
  // N_CH bits set (c=0, or more trailing zeros than channels) are idle slots.
  // The loop runs downward, so the last assignment made is the lowest set bit.
  function automatic slot_t slot_owner(input logic [CNT_W-1:0] c);
    slot_t s;
    s.idle = 1'b1;
    s.ch   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (c[i]) begin
        s.idle = 1'b0;
        s.ch   = CH_W'(i);
      end
    end
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/ro_ch_capture.sv
// ro_ch_capture: event capture for one readout channel.
//   clk_master  master clock
//   rstb        asynchronous active-low reset
//   eve         event level from the core (asynchronous)
//   pol_eve     event polarity from the core (asynchronous)
//   service     this channel owns the current slot and the schedule is enabled
//   ovf_clr     clears the sticky overflow flag
//   pend        an event is waiting for its slot
//   pol         polarity of the waiting event
//   ovf         sticky overflow: an event was dropped while one was pending
module ro_ch_capture (
  input  logic clk_master,
  input  logic rstb,
  input  logic eve,
  input  logic pol_eve,
  input  logic service,
  input  logic ovf_clr,
  output logic pend,
  output logic pol,
  output logic ovf
);

  logic eve_s1, eve_s2, eve_s3;
  logic pol_s1, pol_s2;
  logic rise;

  // eve_s3 resets to 0, so a level already high at reset release is an event.
  assign rise = eve_s2 & ~eve_s3;

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      eve_s1 <= 1'b0;
      eve_s2 <= 1'b0;
      eve_s3 <= 1'b0;
      pol_s1 <= 1'b0;
      pol_s2 <= 1'b0;
      pend   <= 1'b0;
      pol    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      eve_s1 <= eve;
      eve_s2 <= eve_s1;
      eve_s3 <= eve_s2;
      pol_s1 <= pol_eve;
      pol_s2 <= pol_s1;

      // A new event may replace one that is being serviced this very cycle
      // (set beats clear); otherwise the older pending event is kept.
      if (rise && (!pend || service)) begin
        pend <= 1'b1;
        pol  <= pol_s2;
      end else if (service) begin
        pend <= 1'b0;
      end

      if (rise && pend && !service)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/ro_slot_scheduler.sv
// ro_slot_scheduler: binary-weighted time-slot arbiter for the shared readout
// lines of the 8-channel cochlea readout. Owns the slot counter (exported as
// Gray code), captures per-channel events and grants the shared lines: ch0
// gets every second slot, each higher channel half as many.
//   clk_master       master clock
//   rstb             asynchronous active-low reset
//   en               schedule enable (counter advances and slots are serviced)
//   in_eve           per-channel event levels (asynchronous)
//   in_pol_eve       per-channel event polarities
//   ovf_clr          clears all overflow flags
//   gray             Gray-coded slot counter
//   out_mux_eve      serviced event present in the reported slot
//   out_mux_pol_eve  polarity of the serviced event
//   out_ch           owning channel of the reported slot
//   out_valid        reported slot belongs to a channel (not idle)
//   ovf              sticky per-channel overflow
//   frame_mark       (only with RO_FRAME_MARK_EN) outputs describe slot 0
// Build option: define RO_FRAME_MARK_EN to add the frame_mark output.
module ro_slot_scheduler
  import ro_pkg::*;
#(
  parameter int N_CH  = ro_pkg::N_CH,
  parameter int CNT_W = ro_pkg::CNT_W,
  parameter int CH_W  = ro_pkg::CH_W
) (
  input  logic             clk_master,
  input  logic             rstb,
  input  logic             en,
  input  logic [N_CH-1:0]  in_eve,
  input  logic [N_CH-1:0]  in_pol_eve,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] gray,
  output logic             out_mux_eve,
  output logic             out_mux_pol_eve,
  output logic [CH_W-1:0]  out_ch,
  output logic             out_valid,
`ifdef RO_FRAME_MARK_EN
  output logic             frame_mark,
`endif
  output logic [N_CH-1:0]  ovf
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  slot_t            slot;
  logic             slot_live;
  logic [N_CH-1:0]  svc;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  pol;

  assign next_cnt  = en ? cnt + CNT_W'(1) : cnt;
  assign slot      = slot_owner(cnt);
  assign slot_live = en & ~slot.idle;

  always_comb begin
    svc = '0;
    if (slot_live)
      svc[slot.ch] = 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_cap
    ro_ch_capture u_cap (
      .clk_master (clk_master),
      .rstb       (rstb),
      .eve        (in_eve[i]),
      .pol_eve    (in_pol_eve[i]),
      .service    (svc[i]),
      .ovf_clr    (ovf_clr),
      .pend       (pend[i]),
      .pol        (pol[i]),
      .ovf        (ovf[i])
    );
  end

  // gray is computed from next_cnt so it lines up with cnt in the same cycle.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      cnt             <= '0;
      gray            <= '0;
      out_valid       <= 1'b0;
      out_ch          <= '0;
      out_mux_eve     <= 1'b0;
      out_mux_pol_eve <= 1'b0;
    end else begin
      cnt  <= next_cnt;
      gray <= bin2gray(next_cnt);
      if (slot_live) begin
        out_valid       <= 1'b1;
        out_ch          <= slot.ch;
        out_mux_eve     <= pend[slot.ch];
        out_mux_pol_eve <= pend[slot.ch] & pol[slot.ch];
      end else begin
        out_valid       <= 1'b0;
        out_ch          <= '0;
        out_mux_eve     <= 1'b0;
        out_mux_pol_eve <= 1'b0;
      end
    end
  end

`ifdef RO_FRAME_MARK_EN
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb)
      frame_mark <= 1'b0;
    else
      frame_mark <= en && (cnt == '0);
  end
`endif

endmodule

// File: tb/tb_ro_slot_scheduler.sv
// tb_ro_slot_scheduler: directed self-checking bench for ro_slot_scheduler.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ro_slot_scheduler;

  logic       clk_master = 1'b0;
  logic       rstb = 1'b0;
  logic       en = 1'b0;
  logic [7:0] in_eve = '0;
  logic [7:0] in_pol_eve = '0;
  logic       ovf_clr = 1'b0;
  logic [7:0] gray;
  logic       out_mux_eve;
  logic       out_mux_pol_eve;
  logic [2:0] out_ch;
  logic       out_valid;
  logic [7:0] ovf;
`ifdef RO_FRAME_MARK_EN
  logic       frame_mark;
`endif

  int n_checks = 0;
  int n_err = 0;

  // Reference slot count: resets to 0, advances on each clock with en=1.
  logic [7:0] mcnt;

  ro_slot_scheduler dut (
    .clk_master      (clk_master),
    .rstb            (rstb),
    .en              (en),
    .in_eve          (in_eve),
    .in_pol_eve      (in_pol_eve),
    .ovf_clr         (ovf_clr),
    .gray            (gray),
    .out_mux_eve     (out_mux_eve),
    .out_mux_pol_eve (out_mux_pol_eve),
    .out_ch          (out_ch),
    .out_valid       (out_valid),
`ifdef RO_FRAME_MARK_EN
    .frame_mark      (frame_mark),
`endif
    .ovf             (ovf)
  );

  always #5 clk_master = ~clk_master;

  always @(posedge clk_master or negedge rstb) begin
    if (!rstb)
      mcnt <= 8'd0;
    else if (en)
      mcnt <= mcnt + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_master);
  endtask

  // Wait (bounded) until the slot count matches v under mask m.
  task automatic align(input logic [7:0] m, input logic [7:0] v);
    int k;
    k = 0;
    while (((mcnt & m) != v) && k < 300) begin
      @(negedge clk_master);
      k++;
    end
    check("align", 32'(mcnt & m), 32'(v));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] gexp [7];
    logic [7:0] dmask, pmask;
    int dcount, vcnt, ecnt, gerr, d;
    int chc [8];

    gexp = '{8'd1, 8'd3, 8'd2, 8'd6, 8'd7, 8'd5, 8'd4};

    // Reset with every channel's event level high
    rstb = 1'b0; en = 1'b1; in_eve = 8'hFF; in_pol_eve = 8'hA5;
    step(4);
    check("rst_gray", gray, 0);
    check("rst_valid", out_valid, 0);
    check("rst_eve", out_mux_eve, 0);
    check("rst_pol", out_mux_pol_eve, 0);
    check("rst_ch", out_ch, 0);
    check("rst_ovf", ovf, 0);

    rstb = 1'b1;
    dmask = '0; pmask = '0; dcount = 0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (i < 7) check($sformatf("gray_seq%0d", i), gray, gexp[i]);
      if (out_mux_eve) begin
        dcount++;
        dmask[out_ch] = 1'b1;
        pmask[out_ch] = out_mux_pol_eve;
      end
    end
    check("rel_count", dcount, 8);
    check("rel_mask", dmask, 8'hFF);
    check("rel_pol", pmask, 8'hA5);
    check("rel_ovf", ovf, 0);
    in_eve = '0; in_pol_eve = '0;

    // Full schedule period with no events
    vcnt = 0; ecnt = 0; gerr = 0;
    for (int c = 0; c < 8; c++) chc[c] = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      if (out_valid) begin
        vcnt++;
        chc[out_ch]++;
      end
      if (out_mux_eve) ecnt++;
      if (gray !== (mcnt ^ (mcnt >> 1))) gerr++;
    end
    check("sched_valid", vcnt, 255);
    check("sched_eve", ecnt, 0);
    check("sched_gray", gerr, 0);
    for (int c = 0; c < 8; c++) check($sformatf("sched_ch%0d", c), chc[c], 128 >> c);

    // Single event on ch3, pending from slot X+3, serviced at slot X+8
    align(8'h0F, 8'h00);
    in_pol_eve[3] = 1'b1; in_eve[3] = 1'b1;
    step(9);
    check("ev3_ch", out_ch, 3);
    check("ev3_eve", out_mux_eve, 1);
    check("ev3_pol", out_mux_pol_eve, 1);
    check("ev3_valid", out_valid, 1);
    in_eve[3] = 1'b0; in_pol_eve[3] = 1'b0;
    step(16);
    check("ev3_next_ch", out_ch, 3);
    check("ev3_next_eve", out_mux_eve, 0);
    check("ev3_next_valid", out_valid, 1);

    // Overflow on ch7: two edges before its slot at count 128
    align(8'hFF, 8'h00);
    in_pol_eve[7] = 1'b0; in_eve[7] = 1'b1;
    step(3);
    in_eve[7] = 1'b0;
    step(2);
    in_pol_eve[7] = 1'b1;
    step(1);
    in_eve[7] = 1'b1;
    step(4);
    check("ovf7_set", ovf, 8'h80);
    step(119);
    check("ovf7_ch", out_ch, 7);
    check("ovf7_eve", out_mux_eve, 1);
    check("ovf7_pol", out_mux_pol_eve, 0);
    check("ovf7_sticky", ovf, 8'h80);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 0);
    in_eve[7] = 1'b0; in_pol_eve[7] = 1'b0;

    // ch0: edge at odd slot X+2 (set beats clear), second edge at X+4 with service
    align(8'h01, 8'h01);
    in_pol_eve[0] = 1'b0; in_eve[0] = 1'b1;
    step(1);
    in_eve[0] = 1'b0;
    step(1);
    in_eve[0] = 1'b1; in_pol_eve[0] = 1'b1;
    step(1);
    in_eve[0] = 1'b0;
    check("sps_first_eve", out_mux_eve, 0);
    step(2);
    check("sps_old_ch", out_ch, 0);
    check("sps_old_eve", out_mux_eve, 1);
    check("sps_old_pol", out_mux_pol_eve, 0);
    step(2);
    check("sps_new_eve", out_mux_eve, 1);
    check("sps_new_pol", out_mux_pol_eve, 1);
    step(2);
    check("sps_after_eve", out_mux_eve, 0);
    check("sps_ovf", ovf, 0);
    in_pol_eve[0] = 1'b0;

    // Enable gap with a ch2 event pending
    en = 1'b0; in_pol_eve[2] = 1'b1; in_eve[2] = 1'b1;
    vcnt = 0; gerr = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (out_valid) vcnt++;
      if (gray !== (mcnt ^ (mcnt >> 1))) gerr++;
    end
    check("gap_valid", vcnt, 0);
    check("gap_gray", gerr, 0);
    d = (4 - int'(mcnt % 8) + 8) % 8;
    en = 1'b1;
    step(d + 1);
    check("gap_ch", out_ch, 2);
    check("gap_eve", out_mux_eve, 1);
    check("gap_pol", out_mux_pol_eve, 1);
    in_eve[2] = 1'b0; in_pol_eve[2] = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
